// File: rtl/div_iter_pipe.sv
// Iterative restoring divider with valid/ready handshakes, flush cancel and divide-by-zero flag.
// Define DIV_EARLY_EXIT_EN to skip leading-zero iterations of the dividend magnitude.
module div_iter_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flag_unsigned,
  input  logic [WIDTH-1:0]   operand1,
  input  logic [WIDTH-1:0]   operand2,
  input  logic               cancel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               div0
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_reg, b_reg, bmag_reg, acc_reg, sh_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               uns_reg, q_neg_reg, r_neg_reg, div0_pend_reg;
  logic [2*WIDTH-1:0] result_reg;
  logic               div0_reg, in_ready_reg, out_valid_reg;

  logic               a_neg, b_neg, b_zero, trial_ok;
  logic [WIDTH-1:0]   a_mag, b_mag, sh_load, quo_fix, rem_fix;
  logic [CNT_W-1:0]   cnt_load;
  logic [WIDTH:0]     trial;

  assign a_neg  = !uns_reg && a_reg[WIDTH-1];
  assign b_neg  = !uns_reg && b_reg[WIDTH-1];
  assign a_mag  = a_neg ? -a_reg : a_reg;
  assign b_mag  = b_neg ? -b_reg : b_reg;
  assign b_zero = (b_reg == '0);

`ifdef DIV_EARLY_EXIT_EN
  logic [CNT_W-1:0] lz;
  always_comb begin
    lz = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (a_mag[i]) lz = CNT_W'(WIDTH - 1 - i);
    end
  end
  assign sh_load  = a_mag << lz;
  assign cnt_load = CNT_W'(WIDTH) - lz;
`else
  assign sh_load  = a_mag;
  assign cnt_load = CNT_W'(WIDTH);
`endif

  // Full-width partial remainder: acc < |b| keeps 2*acc+1 within WIDTH+1 bits, so bit WIDTH is the borrow.
  assign trial    = {acc_reg, sh_reg[WIDTH-1]} - {1'b0, bmag_reg};
  assign trial_ok = !trial[WIDTH];
  assign quo_fix  = q_neg_reg ? -sh_reg : sh_reg;
  assign rem_fix  = r_neg_reg ? -acc_reg : acc_reg;

  always_comb begin
    state_next = state_reg;
    if (cancel) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: if (in_valid && in_ready_reg) state_next = S_PREP;
        S_PREP: begin
          if (b_zero || cnt_load == '0) state_next = S_FIX;
          else                          state_next = S_ITER;
        end
        S_ITER: if (cnt_reg == CNT_W'(1)) state_next = S_FIX;
        S_FIX:  state_next = S_DONE;
        S_DONE: if (out_ready) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      bmag_reg      <= '0;
      acc_reg       <= '0;
      sh_reg        <= '0;
      cnt_reg       <= '0;
      uns_reg       <= 1'b0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      div0_pend_reg <= 1'b0;
      result_reg    <= '0;
      div0_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      in_ready_reg  <= (state_next == S_IDLE);
      out_valid_reg <= (state_next == S_DONE);
      if (!cancel) begin
        case (state_reg)
          S_IDLE: begin
            if (in_valid && in_ready_reg) begin
              a_reg   <= operand1;
              b_reg   <= operand2;
              uns_reg <= flag_unsigned;
            end
          end
          S_PREP: begin
            q_neg_reg     <= a_neg ^ b_neg;
            r_neg_reg     <= a_neg;
            bmag_reg      <= b_mag;
            div0_pend_reg <= b_zero;
            acc_reg       <= '0;
            sh_reg        <= sh_load;
            cnt_reg       <= cnt_load;
          end
          S_ITER: begin
            acc_reg <= trial_ok ? trial[WIDTH-1:0] : {acc_reg[WIDTH-2:0], sh_reg[WIDTH-1]};
            sh_reg  <= {sh_reg[WIDTH-2:0], trial_ok};
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
          S_FIX: begin
            result_reg <= div0_pend_reg ? {a_reg, {WIDTH{1'b1}}} : {rem_fix, quo_fix};
            div0_reg   <= div0_pend_reg;
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign div0      = div0_reg;

endmodule
